// File: rtl/gr8b0nd_pkg.sv
// gr8b0nd_pkg: shared word size, ld/st opcodes and data-memory responder state encoding
package gr8b0nd_pkg;
  localparam int WORDSIZE = 16;
  localparam logic [7:0] OPld = 8'h40;
  localparam logic [7:0] OPst = 8'h41;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;
endpackage

// File: rtl/gr8b0nd_sram.sv
// gr8b0nd_sram: single-port synchronous DEPTH x WORDSIZE storage, contents never reset
module gr8b0nd_sram
  import gr8b0nd_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_en,
  input  logic                i_we,
  input  logic [AW-1:0]       i_addr,
  input  logic [WORDSIZE-1:0] i_wdata,
  output logic [WORDSIZE-1:0] o_rdata
);
  logic [WORDSIZE-1:0] r_mem [DEPTH];
  logic [WORDSIZE-1:0] r_rdata;
  always_ff @(posedge i_clk)
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else r_rdata <= r_mem[i_addr];
    end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/gr8b0nd_data_mem_responder.sv
// gr8b0nd_data_mem_responder: ld/st responder with configurable wait states and one-cycle ack
module gr8b0nd_data_mem_responder
  import gr8b0nd_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 1024,
  parameter int WAIT_CYC = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [WORDSIZE-1:0] i_wdata,
  output logic                o_ready,
  output logic                o_ack,
  output logic [WORDSIZE-1:0] o_rdata,
  output logic                o_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
  resp_state_t r_state, w_nxt;
  logic [3:0] r_cnt;
  logic r_we, r_err;
  logic [AW-1:0] r_addr, w_sram_addr;
  logic [WORDSIZE-1:0] r_wdata, w_rdata;
  logic w_acc, w_ack, w_rd, w_wr;
  assign w_acc = i_req & (r_state == IDLE);
  assign w_ack = r_state == RESP;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: w_nxt = w_acc ? ((WAIT_CYC == 0) ? RESP : WAIT) : IDLE;
      WAIT: w_nxt = (r_cnt == 4'd0) ? RESP : WAIT;
      RESP: w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_acc) begin
        r_we    <= i_we;
        r_addr  <= i_addr[AW-1:0];
        r_wdata <= i_wdata;
        r_err   <= {1'b0, i_addr} >= LIMIT;
        r_cnt   <= CNT_INIT;
      end else if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
  // Loads are read on the edge entering RESP so the data is present for the whole ack cycle;
  // with no wait states that edge is the accept edge, so the live request fields are used.
  assign w_rd = (r_state == IDLE) ? (w_acc & ~i_we & (WAIT_CYC == 0))
                                  : ((r_state == WAIT) & (r_cnt == 4'd0) & ~r_we);
  assign w_wr = w_ack & r_we & ~r_err;
  assign w_sram_addr = (r_state == IDLE) ? i_addr[AW-1:0] : r_addr;
  gr8b0nd_sram #(.DEPTH(DEPTH), .AW(AW)) u_sram (
    .i_clk   (i_clk),
    .i_en    (w_rd | w_wr),
    .i_we    (w_wr),
    .i_addr  (w_sram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );
  assign o_ready = r_state == IDLE;
  assign o_ack   = w_ack;
  assign o_err   = w_ack & r_err;
  assign o_rdata = (w_ack & ~r_we & ~r_err) ? w_rdata : '0;
endmodule
